// File: rtl/gaussian_pkg.sv
// -----------------------------------------------------------------------------
// gaussian_pkg
//   Shared constants, types and helpers for the 5x5 Gaussian filter blocks.
//
//   KERNEL_SIZE          : window edge length (5)
//   NUM_LINE_MEMS        : number of previous lines kept by the line buffer
//   DEFAULT_PIXEL_WIDTH  : default bits per pixel
//   pixel_t              : pixel word at the default width
//   cnt_width()          : width of a counter/address spanning 0..n-1
// -----------------------------------------------------------------------------
package gaussian_pkg;

    localparam int KERNEL_SIZE         = 5;
    localparam int NUM_LINE_MEMS       = KERNEL_SIZE - 1;
    localparam int DEFAULT_PIXEL_WIDTH = 8;

    typedef logic [DEFAULT_PIXEL_WIDTH-1:0] pixel_t;

    // Bits needed to hold 0..n-1; never less than one so a degenerate
    // dimension still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : gaussian_pkg

// File: rtl/gaussian_line_mem.sv
// -----------------------------------------------------------------------------
// gaussian_line_mem
//   Single-clock simple-dual-port RAM holding one image line.
//   Read is registered and read-before-write: a read and a write to the same
//   address in the same cycle return the old contents.
//
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset of the read register only
//     rd_en    : load rd_data from mem[rd_addr]; rd_data holds otherwise
//     rd_addr  : read address
//     wr_en    : write wr_data to mem[wr_addr]
//     wr_addr  : write address
//     wr_data  : write data
//     rd_data  : registered read data
// -----------------------------------------------------------------------------
import gaussian_pkg::*;

module gaussian_line_mem #(
    parameter  int DEPTH = 640,
    parameter  int WIDTH = DEFAULT_PIXEL_WIDTH,
    localparam int AW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; stale
    // contents are harmless because consumers qualify them with valid flags.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments here are what give read-before-write:
    // the read samples mem before the write above takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : gaussian_line_mem

// File: rtl/gaussian_5x5_line_buffer.sv
// -----------------------------------------------------------------------------
// gaussian_5x5_line_buffer
//   Raster-to-column-slice front end for the 5x5 Gaussian filter. Takes one
//   pixel per cycle in raster order, keeps the four previous lines in line
//   memories and presents the vertical 5-pixel slice (lines y-4..y) at the
//   current column one cycle after each accepted pixel.
//
//   Ports:
//     clk          : clock, rising edge
//     rst          : synchronous active-high reset (counters and outputs)
//     enable       : global advance; low freezes all state and outputs
//     sof          : start of frame, qualified by valid_in; forces (0,0)
//     valid_in     : pixel_in valid
//     pixel_in     : raster pixel
//     win_row_0..4 : slice, line y-4 (oldest) .. line y (current pixel)
//     valid_out    : all five lines hold real frame data (row >= 4)
//     window_valid : slice completes a full 5x5 window (row >= 4, col >= 4)
//     eol_out      : slice is the last column of its line
// -----------------------------------------------------------------------------
import gaussian_pkg::*;

module gaussian_5x5_line_buffer #(
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   sof,
    input  logic                   valid_in,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic [PIXEL_WIDTH-1:0] win_row_0,
    output logic [PIXEL_WIDTH-1:0] win_row_1,
    output logic [PIXEL_WIDTH-1:0] win_row_2,
    output logic [PIXEL_WIDTH-1:0] win_row_3,
    output logic [PIXEL_WIDTH-1:0] win_row_4,
    output logic                   valid_out,
    output logic                   window_valid,
    output logic                   eol_out
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_VAL = ROW_W'(KERNEL_SIZE - 1);

    // -------------------------------------------------------------------------
    // Position of the pixel being accepted
    // -------------------------------------------------------------------------
    logic             accept;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;

    // NOTE: every signal driven here gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        accept  = valid_in && enable;
        pos_col = col;
        pos_row = row;
        if (sof) begin
            pos_col = '0;
            pos_row = '0;
        end
    end

    // Counters hold the position the next accepted pixel will take.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line memory cascade
    //
    // lm0 stores line y-1, lm3 line y-4. Each accept reads all four at the
    // current column. lm0 is written with pixel_in in the same cycle; lm1..lm3
    // take the value just read from their upstream memory, which only exists
    // in that memory's read register one cycle later, so their write is
    // deferred to the next enabled cycle at the saved address. The deferred
    // column is not read again until a full line later, so the slice seen at
    // the outputs is the same as an in-place shift.
    // -------------------------------------------------------------------------
    logic                   wr_pend;
    logic [COL_W-1:0]       wr_col_q;
    logic [NUM_LINE_MEMS-1:0] lm_wr_en;
    logic [COL_W-1:0]       lm_wr_addr [NUM_LINE_MEMS];
    logic [PIXEL_WIDTH-1:0] lm_wr_data [NUM_LINE_MEMS];
    logic [PIXEL_WIDTH-1:0] lm_rd_data [NUM_LINE_MEMS];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend  <= 1'b0;
            wr_col_q <= '0;
        end else if (enable) begin
            wr_pend <= accept;
            if (accept) begin
                wr_col_q <= pos_col;
            end
        end
    end

    for (genvar k = 0; k < NUM_LINE_MEMS; k++) begin : g_lm
        if (k == 0) begin : g_head
            assign lm_wr_en[k]   = accept;
            assign lm_wr_addr[k] = pos_col;
            assign lm_wr_data[k] = pixel_in;
        end else begin : g_tail
            assign lm_wr_en[k]   = enable && wr_pend;
            assign lm_wr_addr[k] = wr_col_q;
            assign lm_wr_data[k] = lm_rd_data[k-1];
        end

        gaussian_line_mem #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (PIXEL_WIDTH)
        ) u_line_mem (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (accept),
            .rd_addr (pos_col),
            .wr_en   (lm_wr_en[k]),
            .wr_addr (lm_wr_addr[k]),
            .wr_data (lm_wr_data[k]),
            .rd_data (lm_rd_data[k])
        );
    end

    // The memory read registers are the older slice rows directly; they
    // already load only on accept and clear on reset.
    assign win_row_3 = lm_rd_data[0];
    assign win_row_2 = lm_rd_data[1];
    assign win_row_1 = lm_rd_data[2];
    assign win_row_0 = lm_rd_data[3];

    // -------------------------------------------------------------------------
    // Current-line pixel and slice flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            win_row_4    <= '0;
            valid_out    <= 1'b0;
            window_valid <= 1'b0;
            eol_out      <= 1'b0;
        end else if (enable) begin
            if (accept) begin
                win_row_4    <= pixel_in;
                valid_out    <= (pos_row >= ROW_FIRST_VAL);
                window_valid <= (pos_row >= ROW_FIRST_VAL) && (pos_col >= COL_FIRST_WIN);
                eol_out      <= (pos_col == COL_LAST);
            end else begin
                // Idle enabled cycle: slice data holds, flags drop.
                valid_out    <= 1'b0;
                window_valid <= 1'b0;
                eol_out      <= 1'b0;
            end
        end
    end

endmodule : gaussian_5x5_line_buffer

// File: tb/tb_gaussian_5x5_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_gaussian_5x5_line_buffer
//   Self-checking bench for gaussian_5x5_line_buffer at IMG_WIDTH=8,
//   IMG_HEIGHT=6. The reference model tracks raster position and, per
//   column, the history of pixels accepted there; a slice is the last four
//   history entries plus the current pixel.
// -----------------------------------------------------------------------------
import gaussian_pkg::*;

module tb_gaussian_5x5_line_buffer;

    localparam int W = 8;
    localparam int H = 6;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   enable = 1'b1;
    logic   sof = 1'b0;
    logic   valid_in = 1'b0;
    pixel_t pixel_in = '0;
    pixel_t win_row_0, win_row_1, win_row_2, win_row_3, win_row_4;
    logic   valid_out, window_valid, eol_out;

    always #5 clk = ~clk;

    gaussian_5x5_line_buffer #(
        .PIXEL_WIDTH (8),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sof          (sof),
        .valid_in     (valid_in),
        .pixel_in     (pixel_in),
        .win_row_0    (win_row_0),
        .win_row_1    (win_row_1),
        .win_row_2    (win_row_2),
        .win_row_3    (win_row_3),
        .win_row_4    (win_row_4),
        .valid_out    (valid_out),
        .window_valid (window_valid),
        .eol_out      (eol_out)
    );

    pixel_t dut_win [5];
    always_comb begin
        dut_win[0] = win_row_0;
        dut_win[1] = win_row_1;
        dut_win[2] = win_row_2;
        dut_win[3] = win_row_3;
        dut_win[4] = win_row_4;
    end

    int tests = 0;
    int fails = 0;

    // Reference model state
    int     mcol = 0;
    int     mrow = 0;
    pixel_t hist [W][$];
    pixel_t exp_win [5];
    logic   exp_v = 1'b0, exp_wv = 1'b0, exp_eol = 1'b0;
    logic   win_known = 1'b1;

    // Stimulus value row*16+col for the position the next pixel will take.
    function automatic pixel_t pos_pix(input logic s);
        int r, c;
        r = s ? 0 : mrow;
        c = s ? 0 : mcol;
        return pixel_t'(r * 16 + c);
    endfunction

    // Drive one cycle, advance the model, leave the bench 1 time unit past
    // the edge so outputs can be compared.
    task automatic step(input logic v, input logic s, input logic en,
                        input logic r, input pixel_t pix);
        int pc, pr, n;
        rst = r; enable = en; valid_in = v; sof = s; pixel_in = pix;
        @(posedge clk);
        if (r) begin
            mcol = 0; mrow = 0;
            for (int k = 0; k < 5; k++) exp_win[k] = '0;
            exp_v = 1'b0; exp_wv = 1'b0; exp_eol = 1'b0;
            win_known = 1'b1;
        end else if (en) begin
            if (v) begin
                pc = s ? 0 : mcol;
                pr = s ? 0 : mrow;
                n  = hist[pc].size();
                exp_win[4] = pix;
                for (int k = 0; k < 4; k++)
                    exp_win[3-k] = (n > k) ? hist[pc][n-1-k] : 'x;
                hist[pc].push_back(pix);
                if (hist[pc].size() > 4) void'(hist[pc].pop_front());
                win_known = (pr >= 4);
                exp_v   = (pr >= 4);
                exp_wv  = (pr >= 4) && (pc >= 4);
                exp_eol = (pc == W - 1);
                if (pc == W - 1) begin
                    mcol = 0;
                    mrow = (pr == H - 1) ? 0 : pr + 1;
                end else begin
                    mcol = pc + 1;
                    mrow = pr;
                end
            end else begin
                exp_v = 1'b0; exp_wv = 1'b0; exp_eol = 1'b0;
            end
        end
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h5a);
        tests++;
        if ({valid_out, window_valid, eol_out} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000", {valid_out, window_valid, eol_out});
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (dut_win[k] !== 8'h00) begin
                fails++;
                $display("FAIL reset_win%0d: got %h expected 00", k, dut_win[k]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_frame();
        pixel_t want_a [5];
        pixel_t want_b [5];
        want_a = '{8'h02, 8'h12, 8'h22, 8'h32, 8'h42};
        want_b = '{8'h14, 8'h24, 8'h34, 8'h44, 8'h54};
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, i == 0, 1'b1, 1'b0, pos_pix(i == 0));
            tests++;
            if ({valid_out, window_valid, eol_out} !== {exp_v, exp_wv, exp_eol}) begin
                fails++;
                $display("FAIL frame_flags i=%0d: got %b expected %b", i,
                         {valid_out, window_valid, eol_out}, {exp_v, exp_wv, exp_eol});
            end
            for (int k = (win_known ? 0 : 4); k < 5; k++) begin
                tests++;
                if (dut_win[k] !== exp_win[k]) begin
                    fails++;
                    $display("FAIL frame_win%0d i=%0d: got %h expected %h", k, i, dut_win[k], exp_win[k]);
                end
            end
            if (i == 4 * W + 2 || i == 5 * W + 4) begin
                for (int k = 0; k < 5; k++) begin
                    tests++;
                    if (dut_win[k] !== ((i == 4 * W + 2) ? want_a[k] : want_b[k])) begin
                        fails++;
                        $display("FAIL frame_slice_const%0d i=%0d: got %h expected %h", k, i,
                                 dut_win[k], (i == 4 * W + 2) ? want_a[k] : want_b[k]);
                    end
                end
                tests++;
                if ({valid_out, window_valid} !== {1'b1, i == 5 * W + 4}) begin
                    fails++;
                    $display("FAIL frame_const_flags i=%0d: got %b expected %b", i,
                             {valid_out, window_valid}, {1'b1, i == 5 * W + 4});
                end
            end
            if (i == W * H - 1) begin
                tests++;
                if (eol_out !== 1'b1) begin
                    fails++;
                    $display("FAIL frame_eol: got %b expected 1", eol_out);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Next frame without sof, random data: valid_out only from row 4 onward.
    task automatic test_wrap();
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, pixel_t'($urandom_range(0, 255)));
            tests++;
            if ({valid_out, window_valid, eol_out} !== {exp_v, exp_wv, exp_eol}) begin
                fails++;
                $display("FAIL wrap_flags i=%0d: got %b expected %b", i,
                         {valid_out, window_valid, eol_out}, {exp_v, exp_wv, exp_eol});
            end
            for (int k = (win_known ? 0 : 4); k < 5; k++) begin
                tests++;
                if (dut_win[k] !== exp_win[k]) begin
                    fails++;
                    $display("FAIL wrap_win%0d i=%0d: got %h expected %h", k, i, dut_win[k], exp_win[k]);
                end
            end
            if (i == 0 || i == 4 * W) begin
                tests++;
                if (valid_out !== (i == 4 * W)) begin
                    fails++;
                    $display("FAIL wrap_valid_edge i=%0d: got %b expected %b", i, valid_out, i == 4 * W);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Three enable-low cycles mid-line with valid_in high: nothing moves.
    task automatic test_stall();
        pixel_t held;
        for (int i = 0; i < W * H; i++) begin
            if (i == 4 * W + 3) begin
                for (int j = 0; j < 3; j++) begin
                    step(1'b1, 1'b0, 1'b0, 1'b0, pixel_t'($urandom_range(0, 255)));
                    tests++;
                    if ({valid_out, window_valid, eol_out, win_row_4} !== {exp_v, exp_wv, exp_eol, exp_win[4]}) begin
                        fails++;
                        $display("FAIL stall_hold j=%0d: got %b/%h expected %b/%h", j,
                                 {valid_out, window_valid, eol_out}, win_row_4,
                                 {exp_v, exp_wv, exp_eol}, exp_win[4]);
                    end
                end
            end
            held = pixel_t'($urandom_range(0, 255));
            step(1'b1, i == 0, 1'b1, 1'b0, held);
            tests++;
            if ({valid_out, window_valid, eol_out} !== {exp_v, exp_wv, exp_eol}) begin
                fails++;
                $display("FAIL stall_flags i=%0d: got %b expected %b", i,
                         {valid_out, window_valid, eol_out}, {exp_v, exp_wv, exp_eol});
            end
            for (int k = (win_known ? 0 : 4); k < 5; k++) begin
                tests++;
                if (dut_win[k] !== exp_win[k]) begin
                    fails++;
                    $display("FAIL stall_win%0d i=%0d: got %h expected %h", k, i, dut_win[k], exp_win[k]);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // sof mid-frame at (3,5), then reset at (4,3), then a sof-less restart.
    task automatic test_sof_reset();
        pixel_t want [5];
        want = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 3 * W + 5; i++)
            step(1'b1, i == 0, 1'b1, 1'b0, pos_pix(i == 0));
        for (int i = 0; i < 4 * W + 3; i++) begin
            step(1'b1, i == 0, 1'b1, 1'b0, pixel_t'($urandom_range(0, 255)));
            tests++;
            if ({valid_out, window_valid, eol_out} !== {exp_v, exp_wv, exp_eol}) begin
                fails++;
                $display("FAIL sof_flags i=%0d: got %b expected %b", i,
                         {valid_out, window_valid, eol_out}, {exp_v, exp_wv, exp_eol});
            end
            for (int k = (win_known ? 0 : 4); k < 5; k++) begin
                tests++;
                if (dut_win[k] !== exp_win[k]) begin
                    fails++;
                    $display("FAIL sof_win%0d i=%0d: got %h expected %h", k, i, dut_win[k], exp_win[k]);
                end
            end
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hee);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (dut_win[k] !== 8'h00) begin
                fails++;
                $display("FAIL rst_mid_win%0d: got %h expected 00", k, dut_win[k]);
            end
        end
        tests++;
        if ({valid_out, window_valid, eol_out} !== 3'b000) begin
            fails++;
            $display("FAIL rst_mid_flags: got %b expected 000", {valid_out, window_valid, eol_out});
        end
        for (int i = 0; i < 4 * W + 1; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, pos_pix(1'b0));
            tests++;
            if (valid_out !== (i == 4 * W)) begin
                fails++;
                $display("FAIL rst_restart_valid i=%0d: got %b expected %b", i, valid_out, i == 4 * W);
            end
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (dut_win[k] !== want[k]) begin
                fails++;
                $display("FAIL rst_restart_win%0d: got %h expected %h", k, dut_win[k], want[k]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Two frames with a gap after every pixel plus occasional extra gaps.
    task automatic test_gaps();
        int gaps;
        for (int i = 0; i < 2 * W * H; i++) begin
            gaps = 1 + (($urandom_range(0, 3) == 0) ? 1 : 0);
            for (int g = 0; g <= gaps; g++) begin
                if (g == 0) step(1'b1, i == 0, 1'b1, 1'b0, pixel_t'($urandom_range(0, 255)));
                else        step(1'b0, 1'b0, 1'b1, 1'b0, pixel_t'($urandom_range(0, 255)));
                tests++;
                if ({valid_out, window_valid, eol_out} !== {exp_v, exp_wv, exp_eol}) begin
                    fails++;
                    $display("FAIL gaps_flags i=%0d g=%0d: got %b expected %b", i, g,
                             {valid_out, window_valid, eol_out}, {exp_v, exp_wv, exp_eol});
                end
                for (int k = (win_known ? 0 : 4); k < 5; k++) begin
                    tests++;
                    if (dut_win[k] !== exp_win[k]) begin
                        fails++;
                        $display("FAIL gaps_win%0d i=%0d g=%0d: got %h expected %h", k, i, g,
                                 dut_win[k], exp_win[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_wrap();
        test_stall();
        test_sof_reset();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_gaussian_5x5_line_buffer

// File: doc/gaussian_5x5_line_buffer.md
Name: gaussian_5x5_line_buffer

Overview:
Raster-to-column-slice front end for the 5x5 Gaussian filter. Accepts one pixel per cycle in raster order and keeps the four previous image lines in line memories. Each cycle it presents the vertical 5-pixel slice (lines y-4..y) at the current column, which is exactly the per-row column-0 feed that gaussian_5x5_core consumes. Its valid_out drives the core's valid_in; both blocks share enable.

Parameters:
PIXEL_WIDTH, 8, bits per pixel
IMG_WIDTH, 640, pixels per line; minimum 5
IMG_HEIGHT, 480, lines per frame; minimum 5

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous and active-high
enable  in  1  global advance; when low, all state and outputs hold
sof  in  1  start of frame; qualified by valid_in, marks the pixel at (row 0, col 0)
valid_in  in  1  pixel_in valid
pixel_in  in  PIXEL_WIDTH  raster pixel
win_row_0  out  PIXEL_WIDTH  pixel at line y-4, current column (oldest)
win_row_1  out  PIXEL_WIDTH  line y-3
win_row_2  out  PIXEL_WIDTH  line y-2
win_row_3  out  PIXEL_WIDTH  line y-1
win_row_4  out  PIXEL_WIDTH  line y (current input pixel, registered)
valid_out  out  1  slice valid: all 5 lines hold real frame data
window_valid  out  1  slice completes a full 5x5 window (col >= 4)
eol_out  out  1  slice is the last column of its line

Behaviour:
- Accept = valid_in && enable. No backpressure; pixels with enable low are dropped.
- Counters: col in [0, IMG_WIDTH-1] and row in [0, IMG_HEIGHT-1], each $clog2-sized.
- Counters use the position of the accepted pixel, and they update on accept.
- Counter stepping: col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At the last pixel of the frame, row wraps to 0.
- sof on an accepted pixel forces its position to (0,0). Counters continue from (0,1).
- A pixel accepted with sof high is treated as (0,0) regardless of counter state, including mid-frame.
- sof without valid_in is ignored.
- Line memories: 4 x IMG_WIDTH words (lm0..lm3), addressed by col. lm0 holds line y-1 and lm3 holds line y-4.
- Memory access on accept: synchronous read-before-write at address col. lm0 writes pixel_in. lmK writes the old read value of lm(K-1).
- Memory contents are never reset. Stale data is masked by valid_out.
- Latency is 1 cycle. The outputs registered after an accept are:
  - win_row_4 = pixel_in
  - win_row_3..0 = read values of lm0..lm3
  - valid_out = (row >= 4)
  - window_valid = (row >= 4 && col >= 4)
  - eol_out = (col == IMG_WIDTH-1)
- Cycle with enable high and no accept: valid_out, window_valid and eol_out go to 0; win_row_* hold.
- Cycle with enable low: everything holds, including the valid flags, so the core sees a frozen slice.
- Slices are not contiguous across valid gaps. The core chain only produces a valid 5x5 result when 5 slices arrive back-to-back; the producer is responsible for gap-free lines.
- Reset (including mid-frame):
  - col=0, row=0
  - all outputs 0
  - the next accepted pixel is (0,0)
- No border replication or padding: lines 0..3 produce no valid slices.

Decomposition:
- gaussian_pkg holds:
  - KERNEL_SIZE = 5
  - NUM_LINE_MEMS = KERNEL_SIZE-1
  - default PIXEL_WIDTH
  - typedef pixel_t
  - the counter-width helper
- Sub-module gaussian_line_mem: single-clock simple-dual-port RAM, IMG_WIDTH x PIXEL_WIDTH, registered read-before-write with an enable.
- Instantiate gaussian_line_mem 4 times. Counters and output registers live in the top.

Test Plan:
Use IMG_WIDTH=8, IMG_HEIGHT=6. The stimulus pixel value is row*16+col.
- Frame with continuous valid, sof on the first pixel -> valid_out=0 for rows 0-3. At row 4 col 2: win_row_0..4 = 0x02,0x12,0x22,0x32,0x42, valid_out=1, window_valid=0.
- Same frame, row 5 col 4 -> win = 0x14,0x24,0x34,0x44,0x54, window_valid=1. At col 7: eol_out=1.
- Frame wrap without sof -> first slice of the next frame has valid_out=0. Rows 0-3 keep valid_out=0; valid_out rises at row 4 with new data only.
- enable low for 3 cycles mid-line -> outputs frozen, input dropped. With the stream held during the stall, the slice sequence after resume is identical to an uninterrupted run.
- sof asserted at row 3 col 5 -> that pixel is (0,0) and valid_out stays 0 for 4 lines. rst pulsed at row 4 col 3 -> all outputs 0 next cycle, and the next pixel is (0,0).
- valid_in gaps of 1 cycle between pixels -> valid_out=0 in gap cycles, win_row_* held, column addressing unchanged.
